// File: rtl/char_frame_receiver_pkg.sv
// Shared types and constants for the serial character receiver.
// Frame layout: start, 5 data bits LSB first, parity, stop.
package char_rx_pkg;

  localparam int             CHAR_W     = 5;
  localparam logic [CHAR_W-1:0] CHAR_MAX   = 5'b10011;
  localparam logic [CHAR_W-1:0] BLANK_CODE = 5'b11111;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // odd=0: even parity over {data,par} is good; odd=1: odd parity is good.
  function automatic logic parity_good(input logic [CHAR_W-1:0] data, input logic par,
                                       input logic odd);
    return (^{data, par}) == odd;
  endfunction

endpackage

// File: rtl/char_frame_receiver_if.sv
// Serial line in, registered character/status out, toward the 7-segment mapper.
// master = receiver side, slave = line driver / display side.
interface char_frame_receiver_if;
  import char_rx_pkg::*;

  logic              rx;
  logic [CHAR_W-1:0] char;
  logic              valid;
  logic              char_stb;
  logic              frame_err;

  modport master (input rx, output char, valid, char_stb, frame_err);
  modport slave  (output rx, input char, valid, char_stb, frame_err);

endinterface

// File: rtl/char_frame_receiver_bit_timer.sv
// Bit-period timer: half_tick marks the start-bit centre, bit_tick every CLKS_PER_BIT cycles.
// Restart reloads the count to zero; no backpressure, free-running otherwise.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic half_tick,
  output logic bit_tick
);

  localparam int          W    = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign half_tick = (cnt == HALF);
  assign bit_tick  = (cnt == LAST);

endmodule

// File: rtl/char_frame_receiver.sv
// Async serial char receiver; char_stb 3 + CLKS_PER_BIT/2 + 7*CLKS_PER_BIT clks after start edge.
// No backpressure: pulses are one cycle; CHAR_RX_RANGE_CHECK_EN also flags codes above CHAR_MAX.
module char_frame_receiver
  import char_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  char_frame_receiver_if.master bus
);

  rx_state_t         state, state_nxt;
  logic              rx_m, rx_s;
  logic              restart, half_tick, bit_tick;
  logic              shift_en, par_en, frame_ok, frame_bad;
  logic [2:0]        bit_cnt;
  logic [CHAR_W-1:0] shreg;
  logic              par_bit;
  logic              good;
  logic [CHAR_W-1:0] char_q;
  logic              valid_q, stb_q, ferr_q;

  // Synchroniser resets to the idle line level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .half_tick (half_tick),
    .bit_tick  (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START:  if (half_tick) state_nxt = rx_s ? IDLE : DATA;
      DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd4) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (rx_s) begin
            frame_ok  = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK:  if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    restart = (state_nxt != state);
  end

`ifdef CHAR_RX_RANGE_CHECK_EN
  assign good = parity_good(shreg, par_bit, PARITY_ODD != 0) && (shreg <= CHAR_MAX);
`else
  assign good = parity_good(shreg, par_bit, PARITY_ODD != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      char_q  <= BLANK_CODE;
      valid_q <= 1'b1;
      stb_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      stb_q  <= frame_ok;
      ferr_q <= frame_bad;
      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg   <= {rx_s, shreg[CHAR_W-1:1]};
      if (par_en)   par_bit <= rx_s;
      // A parity failure still updates char so the display can show "E".
      if (frame_ok) begin
        char_q  <= shreg;
        valid_q <= good;
      end
    end
  end

  assign bus.char      = char_q;
  assign bus.valid     = valid_q;
  assign bus.char_stb  = stb_q;
  assign bus.frame_err = ferr_q;

endmodule
